// File: rtl/tlul_sram_resp.sv
// TL-UL device responder for a single-port, 1-cycle-latency SRAM: checks each A request,
// drives the macro for good ones and returns in-order D responses through a small FIFO.
package tlul_pkg;
  localparam logic [2:0]  PutFullData       = 3'h0;
  localparam logic [2:0]  PutPartialData    = 3'h1;
  localparam logic [2:0]  Get               = 3'h4;
  localparam logic [2:0]  AccessAck         = 3'h0;
  localparam logic [2:0]  AccessAckData     = 3'h1;
  localparam logic [13:0] TL_D_USER_DEFAULT = 14'h0;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_sram_resp
  import tlul_pkg::*;
#(
  parameter int unsigned SramAw   = 10,
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned Depth    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              sram_req_o,
  output logic              sram_we_o,
  output logic [SramAw-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  output logic [31:0]       sram_wmask_o,
  input  logic [31:0]       sram_rdata_i
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1) + 1;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] size;
    logic [7:0] source;
    logic       error;
    logic       is_read;
  } pend_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic        error;
    logic [31:0] data;
  } rsp_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : p + PtrW'(1);
  endfunction

  logic            pend_valid_q, pend_valid_d;
  pend_t           pend_q, pend_d;
  rsp_t            fifo_q [Depth];
  rsp_t            fifo_d [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d, count;

  logic       is_get, is_put, align_bad, range_bad, a_err;
  logic [3:0] full_mask;
  logic       a_ready, accept, d_valid, pop;
  logic       unused_tl;

  assign unused_tl = ^{tl_i.a_param, tl_i.a_user};

  // Classify the request on the A channel; a PutFullData must cover exactly its own bytes.
  always_comb begin
    is_get    = (tl_i.a_opcode == Get);
    is_put    = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    range_bad = (tl_i.a_address[31:SramAw+2] != BaseAddr[31:SramAw+2]);
    case (tl_i.a_size)
      2'd0: begin
        align_bad = 1'b0;
        full_mask = 4'b0001 << tl_i.a_address[1:0];
      end
      2'd1: begin
        align_bad = tl_i.a_address[0];
        full_mask = 4'b0011 << tl_i.a_address[1:0];
      end
      2'd2: begin
        align_bad = |tl_i.a_address[1:0];
        full_mask = 4'b1111;
      end
      default: begin
        align_bad = 1'b1;
        full_mask = 4'b0000;
      end
    endcase
    a_err = !(is_get || is_put) || (tl_i.a_size == 2'd3) || align_bad || range_bad ||
            ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != full_mask));
  end

  assign count   = cnt_q + CntW'(pend_valid_q);
  assign a_ready = !rst_i && (count < CntW'(Depth));
  assign accept  = tl_i.a_valid && a_ready;
  assign d_valid = !rst_i && (cnt_q != {CntW{1'b0}});
  assign pop     = d_valid && tl_i.d_ready;

  // Drive the macro only for accepted, error-free requests.
  always_comb begin
    sram_req_o   = accept && !a_err;
    sram_we_o    = sram_req_o && is_put;
    sram_addr_o  = tl_i.a_address[SramAw+1:2];
    sram_wdata_o = tl_i.a_data;
    for (int i = 0; i < 4; i++) begin
      sram_wmask_o[8*i +: 8] = {8{sram_we_o && tl_i.a_mask[i]}};
    end
  end

  // Pending stage waits one cycle for read data, then joins the response FIFO.
  always_comb begin
    pend_valid_d = accept;
    pend_d       = pend_q;
    if (accept) begin
      pend_d.opcode  = is_get ? AccessAckData : AccessAck;
      pend_d.size    = tl_i.a_size;
      pend_d.source  = tl_i.a_source;
      pend_d.error   = a_err;
      pend_d.is_read = is_get && !a_err;
    end
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    if (pend_valid_q) begin
      fifo_d[wptr_q].opcode = pend_q.opcode;
      fifo_d[wptr_q].size   = pend_q.size;
      fifo_d[wptr_q].source = pend_q.source;
      fifo_d[wptr_q].error  = pend_q.error;
      fifo_d[wptr_q].data   = pend_q.is_read ? sram_rdata_i : 32'h0;
      wptr_d = ptr_inc(wptr_q);
    end
    rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CntW'(pend_valid_q) - CntW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      fifo_q       <= '{default: '0};
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      fifo_q       <= fifo_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = fifo_q[rptr_q].opcode;
    tl_o.d_param  = 3'h0;
    tl_o.d_size   = fifo_q[rptr_q].size;
    tl_o.d_source = fifo_q[rptr_q].source;
    tl_o.d_sink   = 1'b0;
    tl_o.d_data   = fifo_q[rptr_q].data;
    tl_o.d_user   = TL_D_USER_DEFAULT;
    tl_o.d_error  = fifo_q[rptr_q].error;
    tl_o.a_ready  = a_ready;
  end
endmodule

// File: tb/tb_tlul_sram_resp.sv
// Randomised scoreboard bench for tlul_sram_resp with a byte-level memory reference model.
module tb_tlul_sram_resp;
  import tlul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  tl_h2d_t     h2d_a;
  logic        d_ready;
  tl_h2d_t     tl_i;
  tl_d2h_t     tl_o;
  logic        sram_req, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_wmask, sram_rdata;

  always #5 clk = ~clk;

  always_comb begin
    tl_i         = h2d_a;
    tl_i.d_ready = d_ready;
  end

  tlul_sram_resp dut (
    .clk_i(clk), .rst_i(rst), .tl_i(tl_i), .tl_o(tl_o),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_wmask_o(sram_wmask), .sram_rdata_i(sram_rdata)
  );

  // Environment SRAM macro: one-cycle read latency, bit-masked writes.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      else         sram_rdata <= mem[sram_addr];
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic        err;
    logic [31:0] data;
    int          acc;
    bit          exact;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] ref_mem [1024];
  int          n_cmp = 0, n_fail = 0, cyc = 0;
  bit          rnd_mode = 1'b0;
  logic [7:0]  src_ctr = 8'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // TL-UL legality for a 4 KiB window at address 0.
  function automatic bit ref_err(logic [2:0] op, logic [1:0] sz, logic [31:0] addr, logic [3:0] mask);
    int unsigned nbytes, off;
    logic [3:0]  need;
    if (op != 3'h0 && op != 3'h1 && op != 3'h4) return 1'b1;
    if (sz > 2'd2) return 1'b1;
    nbytes = 32'd1 << sz;
    off    = addr % 32'd4;
    if (addr % nbytes != 32'd0) return 1'b1;
    if (addr >= 32'h1000) return 1'b1;
    need = 4'(((32'd1 << nbytes) - 32'd1) << off);
    if (op == 3'h0 && mask != need) return 1'b1;
    return 1'b0;
  endfunction

  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data, output int acc_cyc);
    bit          err, put, done;
    logic [9:0]  w;
    logic [31:0] exp_wm;
    exp_t        e;
    err = ref_err(op, sz, addr, mask);
    put = (op == 3'h0) || (op == 3'h1);
    w   = addr[11:2];
    h2d_a.a_valid   = 1'b1;
    h2d_a.a_opcode  = op;
    h2d_a.a_size    = sz;
    h2d_a.a_address = addr;
    h2d_a.a_mask    = mask;
    h2d_a.a_data    = data;
    h2d_a.a_source  = src_ctr;
    done    = 1'b0;
    acc_cyc = -1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (tl_o.a_ready) begin
        chk("sram_req", sram_req, !err);
        if (!err) begin
          exp_wm = 32'h0;
          for (int i = 0; i < 4; i++) if (put && mask[i]) exp_wm[8*i +: 8] = 8'hFF;
          chk("sram_we", sram_we, put);
          chk("sram_addr", sram_addr, w);
          chk("sram_wmask", sram_wmask, exp_wm);
          if (put) chk("sram_wdata", sram_wdata, data);
        end
        e.op    = (op == 3'h4) ? 3'h1 : 3'h0;
        e.size  = sz;
        e.src   = src_ctr;
        e.err   = err;
        e.data  = (!err && op == 3'h4) ? ref_mem[w] : 32'h0;
        e.acc   = cyc;
        e.exact = (expq.size() == 0) && !rnd_mode && d_ready;
        expq.push_back(e);
        if (!err && put)
          for (int i = 0; i < 4; i++) if (mask[i]) ref_mem[w][8*i +: 8] = data[8*i +: 8];
        acc_cyc = cyc;
        done    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    h2d_a.a_valid = 1'b0;
    src_ctr++;
  endtask

  // Monitor: pops the scoreboard on every completed D beat.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_d_valid", tl_o.d_valid, 1'b0);
      expq.delete();
    end else if (tl_o.d_valid && d_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("d_source", tl_o.d_source, e.src);
        chk("d_opcode", tl_o.d_opcode, e.op);
        chk("d_size", tl_o.d_size, e.size);
        chk("d_error", tl_o.d_error, e.err);
        chk("d_data", tl_o.d_data, e.data);
        chk("d_param_sink_user", {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, 32'h0);
        if (e.exact) chk("latency", cyc - e.acc, 32'd2);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) d_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int          acc, acc3, raise_cyc;
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [31:0] addr, word;
    logic [3:0]  mask;
    int unsigned r;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst     = 1'b1;
    d_ready = 1'b1;
    h2d_a   = '0;
    h2d_a.a_valid   = 1'b1;
    h2d_a.a_opcode  = Get;
    h2d_a.a_size    = 2'd2;
    h2d_a.a_address = 32'h10;
    h2d_a.a_mask    = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_a_ready", tl_o.a_ready, 1'b0);
      chk("rst_sram_req", sram_req, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    h2d_a.a_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_a_ready", tl_o.a_ready, 1'b1);
    @(posedge clk);
    #1;

    send(3'h0, 2'd2, 32'h10,   4'hF, 32'hDEADBEEF, acc);
    send(3'h4, 2'd2, 32'h10,   4'hF, 32'h0,        acc);
    send(3'h1, 2'd2, 32'h10,   4'h2, 32'h0000AA00, acc);
    send(3'h4, 2'd2, 32'h10,   4'hF, 32'h0,        acc);
    send(3'h4, 2'd2, 32'h1002, 4'hF, 32'h0,        acc);
    send(3'h4, 2'd2, 32'h4000, 4'hF, 32'h0,        acc);
    send(3'h5, 2'd2, 32'h20,   4'hF, 32'h12345678, acc);
    send(3'h0, 2'd0, 32'h23,   4'h8, 32'h77000000, acc);
    send(3'h4, 2'd2, 32'h20,   4'hF, 32'h0,        acc);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two accepted, third waits for the first pop.
    d_ready = 1'b0;
    fork
      begin
        send(3'h4, 2'd2, 32'h10, 4'hF, 32'h0, acc);
        send(3'h4, 2'd2, 32'h20, 4'hF, 32'h0, acc);
        send(3'h4, 2'd2, 32'h30, 4'hF, 32'h0, acc3);
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_a_ready", tl_o.a_ready, 1'b0);
        chk("bp_d_valid", tl_o.d_valid, 1'b1);
        @(posedge clk);
        #1;
        d_ready   = 1'b1;
        raise_cyc = cyc;
      end
    join
    chk("bp_third_accept", acc3, raise_cyc + 1);
    repeat (4) @(posedge clk);
    #1;

    // Reset with two requests in flight.
    d_ready = 1'b0;
    send(3'h4, 2'd2, 32'h10, 4'hF, 32'h0, acc);
    send(3'h4, 2'd2, 32'h14, 4'hF, 32'h0, acc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    d_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_d_valid", tl_o.d_valid, 1'b0);
      chk("flush_a_ready", tl_o.a_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    send(3'h4, 2'd2, 32'h10, 4'hF, 32'h0, acc);
    repeat (4) @(posedge clk);
    #1;

    rnd_mode = 1'b1;
    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r < 4)       op = 3'h4;
      else if (r < 6)  op = 3'h0;
      else if (r < 8)  op = 3'h1;
      else if (r == 8) op = 3'h5;
      else             op = 3'($urandom_range(0, 7));
      sz   = ($urandom_range(0, 7) < 5) ? 2'd2 : 2'($urandom_range(0, 3));
      word = ($urandom_range(0, 9) == 0) ? 32'(1008 + $urandom_range(0, 15)) : 32'($urandom_range(0, 15));
      addr = word * 32'd4;
      if (sz == 2'd0) addr = addr + 32'($urandom_range(0, 3));
      if (sz == 2'd1) addr = addr + 32'(2 * $urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 14) == 0) addr = addr | (32'h1000 << $urandom_range(0, 19));
      if (op == 3'h0 && $urandom_range(0, 7) != 0 && sz != 2'd3)
        mask = 4'(((32'd1 << (32'd1 << sz)) - 32'd1) << addr[1:0]);
      else
        mask = 4'($urandom_range(0, 15));
      send(op, sz, addr, mask, $urandom, acc);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_mode = 1'b0;
    d_ready  = 1'b1;
    for (int t = 0; t < 500 && expq.size() != 0; t++) @(posedge clk);
    chk("drain", expq.size(), 32'd0);
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
